// File: rtl/lcd1602_seq_ctrl_if.sv
// Request handshake between fabric logic and the LCD1602 sequencer.
// One byte (command or character) per valid/ready transfer.
interface lcd1602_seq_ctrl_if;
    logic       iVALID;
    logic       iRS;
    logic [7:0] iDATA;
    logic       oREADY;

    modport master (output iVALID, output iRS, output iDATA, input oREADY);
    modport slave  (input iVALID, input iRS, input iDATA, output oREADY);
endinterface

// File: rtl/lcd1602_seq_ctrl.sv
// HD44780 16x2 LCD write sequencer: power-up init, then one byte per request.
// Define LCD_AUTOWRAP_EN for cursor tracking with automatic line wrap.
module lcd1602_seq_ctrl #(
    parameter int T_POWERUP = 2000000,
    parameter int T_AS      = 4,
    parameter int T_PW      = 12,
    parameter int T_CMD     = 2500,
    parameter int T_CLEAR   = 82000
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    lcd1602_seq_ctrl_if.slave        bus,
    output logic                     oINIT_DONE,
    output logic [7:0]               oLCD_D,
    output logic                     oLCD_RS,
    output logic                     oLCD_RW,
    output logic                     oLCD_EN
);
    // A zero-length phase would be unreachable with a terminal-count compare.
    localparam int L_PU  = (T_POWERUP < 1) ? 1 : T_POWERUP;
    localparam int L_AS  = (T_AS < 1)      ? 1 : T_AS;
    localparam int L_PW  = (T_PW < 1)      ? 1 : T_PW;
    localparam int L_CMD = (T_CMD < 1)     ? 1 : T_CMD;
    localparam int L_CLR = (T_CLEAR < 1)   ? 1 : T_CLEAR;
    localparam int M1    = (L_PU > L_CLR) ? L_PU : L_CLR;
    localparam int M2    = (M1 > L_CMD)   ? M1   : L_CMD;
    localparam int M3    = (M2 > L_PW)    ? M2   : L_PW;
    localparam int L_MAX = (M3 > L_AS)    ? M3   : L_AS;
    localparam int CW    = $clog2(L_MAX + 1);

    localparam logic [CW-1:0] C_PU  = CW'(L_PU - 1);
    localparam logic [CW-1:0] C_AS  = CW'(L_AS - 1);
    localparam logic [CW-1:0] C_PW  = CW'(L_PW - 1);
    localparam logic [CW-1:0] C_CMD = CW'(L_CMD - 1);
    localparam logic [CW-1:0] C_CLR = CW'(L_CLR - 1);
    localparam logic [2:0]    N_INIT = 3'd5;

    typedef enum logic [2:0] {
        ST_PWRUP, ST_LOAD, ST_SETUP, ST_EN_HI, ST_WAIT, ST_IDLE
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n, w_last;
    logic [2:0]    r_idx, w_idx_n;
    logic [7:0]    r_d, w_d_n;
    logic          r_rs, w_rs_n;
    logic          r_done, w_done_n;
    logic          w_long;
`ifdef LCD_AUTOWRAP_EN
    logic          r_row, w_row_n;
    logic [3:0]    r_col, w_col_n;
`endif

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_rom = 8'h38;
            3'd2:       init_rom = 8'h0C;
            3'd3:       init_rom = 8'h01;
            default:    init_rom = 8'h06;
        endcase
    endfunction

    // Clear and return-home need the long settle time after E falls.
    always_comb begin
        w_long = !r_rs && (r_d[7:2] == 6'd0) && (r_d != 8'd0);
        case (r_state)
            ST_PWRUP: w_last = C_PU;
            ST_SETUP: w_last = C_AS;
            ST_EN_HI: w_last = C_PW;
            ST_WAIT:  w_last = w_long ? C_CLR : C_CMD;
            default:  w_last = '0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_idx_n   = r_idx;
        w_d_n     = r_d;
        w_rs_n    = r_rs;
        w_done_n  = r_done;
`ifdef LCD_AUTOWRAP_EN
        w_row_n   = r_row;
        w_col_n   = r_col;
`endif
        case (r_state)
            ST_PWRUP: if (r_cnt == w_last) begin
                w_state_n = ST_LOAD;
                w_cnt_n   = '0;
            end
            ST_LOAD: begin
                w_d_n     = init_rom(r_idx);
                w_rs_n    = 1'b0;
                w_idx_n   = r_idx + 1'b1;
                w_cnt_n   = '0;
                w_state_n = ST_SETUP;
            end
            ST_SETUP: if (r_cnt == w_last) begin
                w_state_n = ST_EN_HI;
                w_cnt_n   = '0;
            end
            ST_EN_HI: if (r_cnt == w_last) begin
                w_state_n = ST_WAIT;
                w_cnt_n   = '0;
            end
            ST_WAIT: if (r_cnt == w_last) begin
                w_cnt_n = '0;
                if (!r_done && (r_idx != N_INIT)) begin
                    w_state_n = ST_LOAD;
                end else if (!r_done) begin
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_state_n = ST_IDLE;
`ifdef LCD_AUTOWRAP_EN
                    // The inserted set-DDRAM command updates the cursor itself via the D[7] rule.
                    if (r_rs) begin
                        if (r_col == 4'd15) begin
                            w_d_n     = r_row ? 8'h80 : 8'hC0;
                            w_rs_n    = 1'b0;
                            w_state_n = ST_SETUP;
                        end else begin
                            w_col_n = r_col + 1'b1;
                        end
                    end else if (w_long) begin
                        w_row_n = 1'b0;
                        w_col_n = 4'd0;
                    end else if (r_d[7]) begin
                        w_row_n = r_d[6];
                        w_col_n = r_d[3:0];
                    end
`endif
                end
            end
            ST_IDLE: begin
                w_cnt_n = '0;
                if (bus.iVALID) begin
                    w_d_n     = bus.iDATA;
                    w_rs_n    = bus.iRS;
                    w_state_n = ST_SETUP;
                end
            end
            default: begin
                w_state_n = ST_PWRUP;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_PWRUP;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_d     <= 8'h00;
            r_rs    <= 1'b0;
            r_done  <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            r_row   <= 1'b0;
            r_col   <= 4'd0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_d     <= w_d_n;
            r_rs    <= w_rs_n;
            r_done  <= w_done_n;
`ifdef LCD_AUTOWRAP_EN
            r_row   <= w_row_n;
            r_col   <= w_col_n;
`endif
        end
    end

    // E decodes straight from the state register so reset removes it at once.
    assign bus.oREADY = (r_state == ST_IDLE);
    assign oLCD_EN    = (r_state == ST_EN_HI);
    assign oLCD_D     = r_d;
    assign oLCD_RS    = r_rs;
    assign oLCD_RW    = 1'b0;
    assign oINIT_DONE = r_done;
endmodule

// File: tb/tb_lcd1602_seq_ctrl.sv
// Self-checking bench for lcd1602_seq_ctrl using shortened timing parameters.
// Reference model works from E-pulse lists and cycle arithmetic; covers LCD_AUTOWRAP_EN when defined.
module tb_lcd1602_seq_ctrl;
    localparam int P_PU  = 10;
    localparam int P_AS  = 2;
    localparam int P_PW  = 3;
    localparam int P_CMD = 5;
    localparam int P_CLR = 20;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         rise;
        int         fall;
        bit         stable;
    } pulse_t;

    typedef struct {
        logic [7:0] d;
        logic       rs;
    } exp_t;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       oINIT_DONE;
    logic [7:0] oLCD_D;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic       oLCD_EN;

    lcd1602_seq_ctrl_if bus ();

    lcd1602_seq_ctrl #(
        .T_POWERUP(P_PU), .T_AS(P_AS), .T_PW(P_PW), .T_CMD(P_CMD), .T_CLEAR(P_CLR)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .bus(bus),
        .oINIT_DONE(oINIT_DONE),
        .oLCD_D(oLCD_D),
        .oLCD_RS(oLCD_RS),
        .oLCD_RW(oLCD_RW),
        .oLCD_EN(oLCD_EN)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int nCmp = 0;
    int nBad = 0;

    // Every completed E pulse is logged with its byte and edge times (sampled on negedge).
    pulse_t pq[$];
    pulse_t cur;
    bit     prevEn = 1'b0;
    bit     rwBad = 1'b0;
    always @(negedge iCLK) begin
        if (oLCD_RW !== 1'b0) rwBad = 1'b1;
        if (oLCD_EN === 1'b1 && !prevEn) begin
            cur.d = oLCD_D; cur.rs = oLCD_RS; cur.rise = cyc; cur.fall = 0; cur.stable = 1'b1;
        end else if (oLCD_EN === 1'b1) begin
            if (oLCD_D !== cur.d || oLCD_RS !== cur.rs) cur.stable = 1'b0;
        end else if (prevEn) begin
            cur.fall = cyc;
            pq.push_back(cur);
        end
        prevEn = (oLCD_EN === 1'b1);
    end

    // Reference model: expected pulses per request and the cursor position.
    exp_t expQ[$];
    bit   mRow;
    int   mCol;

    function automatic int waitOf(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? P_CLR : P_CMD;
    endfunction

    task automatic modelTxn(input logic rs, input logic [7:0] d);
        exp_t e;
        e.d = d; e.rs = rs;
        expQ.push_back(e);
`ifdef LCD_AUTOWRAP_EN
        if (rs) begin
            if (mCol == 15) begin
                e.d = mRow ? 8'h80 : 8'hC0; e.rs = 1'b0;
                expQ.push_back(e);
                mRow = !mRow; mCol = 0;
            end else begin
                mCol++;
            end
        end else if (d >= 8'd1 && d <= 8'd3) begin
            mRow = 1'b0; mCol = 0;
        end else if (d[7]) begin
            mRow = d[6]; mCol = int'(d[3:0]);
        end
`endif
    endtask

    // Drives one request once ready, then waits for ready to come back.
    task automatic applyStimulus(input logic rs, input logic [7:0] d, output int accCyc,
                                 output int rdyCyc, output bit readyFell, output bit timedOut);
        int n;
        accCyc = 0; rdyCyc = 0; readyFell = 1'b0; timedOut = 1'b0;
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 2000) begin @(negedge iCLK); n++; end
        if (n >= 2000) begin timedOut = 1'b1; return; end
        bus.iVALID = 1'b1; bus.iRS = rs; bus.iDATA = d;
        @(negedge iCLK);
        bus.iVALID = 1'b0; bus.iRS = 1'($urandom); bus.iDATA = 8'($urandom);
        accCyc = cyc;
        readyFell = (bus.oREADY === 1'b0);
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 2000) begin @(negedge iCLK); n++; end
        rdyCyc = cyc;
        timedOut = (n >= 2000);
    endtask

    task automatic test_reset_init(input bit holdValid);
        int rel, n, tEdge;
        bit earlyReady;
        logic [7:0] initB [5];
        initB = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        iRST_N = 1'b0;
        bus.iVALID = holdValid; bus.iRS = 1'($urandom); bus.iDATA = 8'($urandom);
        repeat (3) @(negedge iCLK);
        nCmp++; if (bus.oREADY !== 1'b0) begin nBad++; $display("[TB] FAIL rst_ready: got %b want 0", bus.oREADY); end
        nCmp++; if (oINIT_DONE !== 1'b0) begin nBad++; $display("[TB] FAIL rst_done: got %b want 0", oINIT_DONE); end
        nCmp++; if (oLCD_EN !== 1'b0) begin nBad++; $display("[TB] FAIL rst_en: got %b want 0", oLCD_EN); end
        nCmp++; if (oLCD_RS !== 1'b0) begin nBad++; $display("[TB] FAIL rst_rs: got %b want 0", oLCD_RS); end
        nCmp++; if (oLCD_RW !== 1'b0) begin nBad++; $display("[TB] FAIL rst_rw: got %b want 0", oLCD_RW); end
        nCmp++; if (oLCD_D !== 8'h00) begin nBad++; $display("[TB] FAIL rst_d: got %h want 00", oLCD_D); end
        pq.delete(); expQ.delete(); mRow = 1'b0; mCol = 0;
        iRST_N = 1'b1;
        rel = cyc;
        earlyReady = 1'b0;
        n = 0;
        while (oINIT_DONE !== 1'b1 && n < 500) begin
            if (bus.oREADY !== 1'b0) earlyReady = 1'b1;
            if (holdValid) begin bus.iRS = 1'($urandom); bus.iDATA = 8'($urandom); end
            @(negedge iCLK); n++;
        end
        bus.iVALID = 1'b0;
        nCmp++; if (n >= 500) begin nBad++; $display("[TB] FAIL init_timeout: waited %0d cycles, want done", n); end
        nCmp++; if (earlyReady) begin nBad++; $display("[TB] FAIL init_early_ready: got 1 want 0 before done"); end
        nCmp++; if (bus.oREADY !== 1'b1) begin nBad++; $display("[TB] FAIL init_ready_with_done: got %b want 1", bus.oREADY); end
        nCmp++; if (pq.size() != 5) begin nBad++; $display("[TB] FAIL init_count: got %0d pulses want 5", pq.size()); end
        // The LOAD cycle adds one extra cycle before each init SETUP.
        tEdge = rel + P_PU + 1;
        for (int k = 0; k < 5 && k < pq.size(); k++) begin
            nCmp++; if (pq[k].d !== initB[k] || pq[k].rs !== 1'b0)
                begin nBad++; $display("[TB] FAIL init_byte%0d: got %h/%b want %h/0", k, pq[k].d, pq[k].rs, initB[k]); end
            nCmp++; if (pq[k].rise - tEdge !== P_AS)
                begin nBad++; $display("[TB] FAIL init_rise%0d: got %0d want %0d", k, pq[k].rise - rel, tEdge + P_AS - rel); end
            nCmp++; if (pq[k].fall - pq[k].rise !== P_PW)
                begin nBad++; $display("[TB] FAIL init_width%0d: got %0d want %0d", k, pq[k].fall - pq[k].rise, P_PW); end
            tEdge = pq[k].fall + waitOf(1'b0, initB[k]) + 1;
        end
        nCmp++; if (cyc !== tEdge - 1) begin nBad++; $display("[TB] FAIL init_done_time: got %0d want %0d", cyc - rel, tEdge - 1 - rel); end
        pq.delete();
    endtask

    task automatic test_data_write();
        int acc, rdy;
        bit fell, tmo;
        pq.delete(); expQ.delete();
        modelTxn(1'b1, 8'h41);
        applyStimulus(1'b1, 8'h41, acc, rdy, fell, tmo);
        nCmp++; if (tmo) begin nBad++; $display("[TB] FAIL dw_timeout: got timeout want ready"); end
        nCmp++; if (fell !== 1'b1) begin nBad++; $display("[TB] FAIL dw_ready_fall: got %b want 1", fell); end
        nCmp++; if (rdy - acc !== P_AS + P_PW + P_CMD) begin nBad++; $display("[TB] FAIL dw_busy: got %0d want %0d", rdy - acc, P_AS + P_PW + P_CMD); end
        nCmp++; if (pq.size() != 1) begin nBad++; $display("[TB] FAIL dw_count: got %0d want 1", pq.size()); end
        if (pq.size() >= 1) begin
            nCmp++; if (pq[0].d !== 8'h41 || pq[0].rs !== 1'b1) begin nBad++; $display("[TB] FAIL dw_byte: got %h/%b want 41/1", pq[0].d, pq[0].rs); end
            nCmp++; if (pq[0].fall - pq[0].rise !== P_PW) begin nBad++; $display("[TB] FAIL dw_width: got %0d want %0d", pq[0].fall - pq[0].rise, P_PW); end
            nCmp++; if (pq[0].rise - acc !== P_AS) begin nBad++; $display("[TB] FAIL dw_rise: got %0d want %0d", pq[0].rise - acc, P_AS); end
            nCmp++; if (pq[0].stable !== 1'b1) begin nBad++; $display("[TB] FAIL dw_stable: got %b want 1", pq[0].stable); end
        end
        nCmp++; if (rwBad !== 1'b0) begin nBad++; $display("[TB] FAIL dw_rw: got %b want 0", rwBad); end
        nCmp++; if (oLCD_D !== 8'h41) begin nBad++; $display("[TB] FAIL dw_hold_d: got %h want 41", oLCD_D); end
    endtask

    task automatic test_clear_hold();
        int n, a, r1, r2;
        pq.delete(); expQ.delete();
        modelTxn(1'b0, 8'h01);
        modelTxn(1'b1, 8'h42);
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 2000) begin @(negedge iCLK); n++; end
        bus.iVALID = 1'b1; bus.iRS = 1'b0; bus.iDATA = 8'h01;
        @(negedge iCLK);
        a = cyc;
        bus.iRS = 1'b1; bus.iDATA = 8'h42;
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 2000) begin @(negedge iCLK); n++; end
        r1 = cyc;
        nCmp++; if (r1 - a !== P_AS + P_PW + P_CLR) begin nBad++; $display("[TB] FAIL clr_busy: got %0d want %0d", r1 - a, P_AS + P_PW + P_CLR); end
        @(negedge iCLK);
        nCmp++; if (bus.oREADY !== 1'b0) begin nBad++; $display("[TB] FAIL hold_first_accept: got ready %b want 0", bus.oREADY); end
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 2000) begin @(negedge iCLK); n++; end
        r2 = cyc;
        bus.iVALID = 1'b0;
        nCmp++; if (r2 - (r1 + 1) !== P_AS + P_PW + P_CMD) begin nBad++; $display("[TB] FAIL hold_busy: got %0d want %0d", r2 - r1 - 1, P_AS + P_PW + P_CMD); end
        nCmp++; if (pq.size() != 2) begin nBad++; $display("[TB] FAIL hold_count: got %0d want 2", pq.size()); end
        for (int k = 0; k < 2 && k < pq.size(); k++) begin
            nCmp++; if (pq[k].d !== expQ[k].d || pq[k].rs !== expQ[k].rs)
                begin nBad++; $display("[TB] FAIL hold_byte%0d: got %h/%b want %h/%b", k, pq[k].d, pq[k].rs, expQ[k].d, expQ[k].rs); end
        end
        @(negedge iCLK);
        nCmp++; if (bus.oREADY !== 1'b1) begin nBad++; $display("[TB] FAIL hold_no_second: got ready %b want 1", bus.oREADY); end
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        n = 0;
        while (bus.oREADY !== 1'b1 && n < 2000) begin @(negedge iCLK); n++; end
        bus.iVALID = 1'b1; bus.iRS = 1'b1; bus.iDATA = 8'h5A;
        @(negedge iCLK);
        bus.iVALID = 1'b0;
        n = 0;
        while (oLCD_EN !== 1'b1 && n < 50) begin @(negedge iCLK); n++; end
        nCmp++; if (oLCD_EN !== 1'b1) begin nBad++; $display("[TB] FAIL mid_no_pulse: got %b want 1", oLCD_EN); end
        #2 iRST_N = 1'b0;
        #1;
        nCmp++; if (oLCD_EN !== 1'b0) begin nBad++; $display("[TB] FAIL mid_en_drop: got %b want 0", oLCD_EN); end
        nCmp++; if (bus.oREADY !== 1'b0 || oINIT_DONE !== 1'b0)
            begin nBad++; $display("[TB] FAIL mid_flags: got ready %b done %b want 0 0", bus.oREADY, oINIT_DONE); end
        nCmp++; if (oLCD_D !== 8'h00 || oLCD_RS !== 1'b0)
            begin nBad++; $display("[TB] FAIL mid_bus: got %h/%b want 00/0", oLCD_D, oLCD_RS); end
        @(negedge iCLK);
    endtask

    task automatic test_random();
        logic rsv;
        logic [7:0] dv;
        int acc, rdy, tEdge;
        bit fell, tmo;
        for (int t = 0; t < 14; t++) begin
            rsv = 1'($urandom_range(0, 1));
            dv = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
            pq.delete(); expQ.delete();
            modelTxn(rsv, dv);
            applyStimulus(rsv, dv, acc, rdy, fell, tmo);
            nCmp++; if (tmo) begin nBad++; $display("[TB] FAIL rnd%0d_timeout: got timeout want ready", t); end
            nCmp++; if (fell !== 1'b1) begin nBad++; $display("[TB] FAIL rnd%0d_ready_fall: got %b want 1", t, fell); end
            nCmp++; if (pq.size() != expQ.size()) begin nBad++; $display("[TB] FAIL rnd%0d_count: got %0d want %0d", t, pq.size(), expQ.size()); end
            tEdge = acc;
            for (int k = 0; k < expQ.size() && k < pq.size(); k++) begin
                nCmp++; if (pq[k].d !== expQ[k].d || pq[k].rs !== expQ[k].rs)
                    begin nBad++; $display("[TB] FAIL rnd%0d_byte%0d: got %h/%b want %h/%b", t, k, pq[k].d, pq[k].rs, expQ[k].d, expQ[k].rs); end
                nCmp++; if (pq[k].rise - tEdge !== P_AS)
                    begin nBad++; $display("[TB] FAIL rnd%0d_rise%0d: got %0d want %0d", t, k, pq[k].rise - tEdge, P_AS); end
                nCmp++; if (pq[k].fall - pq[k].rise !== P_PW)
                    begin nBad++; $display("[TB] FAIL rnd%0d_width%0d: got %0d want %0d", t, k, pq[k].fall - pq[k].rise, P_PW); end
                tEdge = pq[k].fall + waitOf(expQ[k].rs, expQ[k].d);
            end
            nCmp++; if (rdy !== tEdge) begin nBad++; $display("[TB] FAIL rnd%0d_ready_time: got %0d want %0d", t, rdy - acc, tEdge - acc); end
        end
    endtask

`ifdef LCD_AUTOWRAP_EN
    task automatic test_autowrap();
        int acc, rdy, tEdge;
        bit fell, tmo;
        logic [7:0] dv;
        pq.delete(); expQ.delete();
        modelTxn(1'b0, 8'h80);
        applyStimulus(1'b0, 8'h80, acc, rdy, fell, tmo);
        for (int i = 0; i < 32; i++) begin
            dv = 8'h30 + 8'(i % 16);
            pq.delete(); expQ.delete();
            modelTxn(1'b1, dv);
            applyStimulus(1'b1, dv, acc, rdy, fell, tmo);
            nCmp++; if (pq.size() != expQ.size()) begin nBad++; $display("[TB] FAIL wrap%0d_count: got %0d want %0d", i, pq.size(), expQ.size()); end
            tEdge = acc;
            for (int k = 0; k < expQ.size() && k < pq.size(); k++) begin
                nCmp++; if (pq[k].d !== expQ[k].d || pq[k].rs !== expQ[k].rs)
                    begin nBad++; $display("[TB] FAIL wrap%0d_byte%0d: got %h/%b want %h/%b", i, k, pq[k].d, pq[k].rs, expQ[k].d, expQ[k].rs); end
                tEdge = pq[k].fall + waitOf(expQ[k].rs, expQ[k].d);
            end
            nCmp++; if (rdy !== tEdge) begin nBad++; $display("[TB] FAIL wrap%0d_ready_time: got %0d want %0d", i, rdy - acc, tEdge - acc); end
            if (i == 15 || i == 31) begin
                nCmp++; if (pq.size() < 2 || pq[pq.size()-1].d !== ((i == 15) ? 8'hC0 : 8'h80) || pq[pq.size()-1].rs !== 1'b0)
                    begin nBad++; $display("[TB] FAIL wrap_insert%0d: got %0d pulses want inserted %h", i, pq.size(), (i == 15) ? 8'hC0 : 8'h80); end
            end
        end
    endtask
`endif

    initial begin
        bus.iVALID = 1'b0; bus.iRS = 1'b0; bus.iDATA = 8'h00;
        iRST_N = 1'b0;
        $display("[TB] start");
        test_reset_init(1'b0);
        test_data_write();
        test_clear_hold();
        test_reset_mid_transfer();
        test_reset_init(1'b0);
        test_reset_init(1'b1);
        test_random();
`ifdef LCD_AUTOWRAP_EN
        test_autowrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
